// File: rtl/riscv_pkg.sv
// Shared RV32 decode constants: instruction width, base opcodes and immediate formats.
package riscv_pkg;

  localparam int INST_W = 32;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J} imm_fmt_e;

  function automatic imm_fmt_e imm_fmt(input logic [6:0] op);
    case (op)
      OP_LOAD, OP_IMM, OP_JALR: imm_fmt = FMT_I;
      OP_STORE:                 imm_fmt = FMT_S;
      OP_BRANCH:                imm_fmt = FMT_B;
      OP_LUI, OP_AUIPC:         imm_fmt = FMT_U;
      OP_JAL:                   imm_fmt = FMT_J;
      default:                  imm_fmt = FMT_R;
    endcase
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Power-of-two FIFO with synchronous flush; head is read combinationally.
module fetch_fifo #(
  parameter int WIDTH = 48,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr, wr_ptr;
  logic             do_push, do_pop, clr;

  assign clr     = rst || flush;
  assign do_pop  = pop && (count != '0);
  // A push into a full queue is only legal when a pop frees the slot this cycle.
  assign do_push = push && ((count != FULL_CNT) || do_pop);
  assign head_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push && !clr) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/instr_fetch_queue.sv
// Sequential instruction fetcher with credit-limited prefetch queue and inline RV32 field/immediate decode.
module instr_fetch_queue
  import riscv_pkg::*;
#(
  parameter int                ADDR_W   = 16,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [INST_W-1:0] mem_rdata,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_pc,
  output logic [6:0]        out_opcode,
  output logic [4:0]        out_rd,
  output logic [2:0]        out_funct3,
  output logic [4:0]        out_rs1,
  output logic [4:0]        out_rs2,
  output logic [6:0]        out_funct7,
  output logic [31:0]       out_imm
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = DEPTH[CW-1:0];

  logic [ADDR_W-1:0]        pc, inflight_pc;
  logic                     inflight, issue, push, pop;
  logic [CW-1:0]            count, occ;
  logic [ADDR_W+INST_W-1:0] head;
  logic [INST_W-1:0]        inst;

  // Credit counts the outstanding response but deliberately ignores a same-cycle pop.
  assign occ     = count + CW'(inflight);
  assign issue   = !rst && !redirect && (occ < DEPTH_C);
  assign mem_req = issue;
  assign mem_addr = pc;

  assign push = inflight && !redirect && !rst;
  assign pop  = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else if (redirect) begin
      pc       <= redirect_pc;
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        pc          <= pc + ADDR_W'(1);
        inflight_pc <= pc;
      end
    end
  end

  fetch_fifo #(.WIDTH(ADDR_W + INST_W), .DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect),
    .push      (push),
    .push_data ({inflight_pc, mem_rdata}),
    .pop       (pop),
    .head_data (head),
    .count     (count)
  );

  assign out_valid = !rst && (count != '0);
  // Zero the head view when empty so every field reads 0 in reset and idle.
  assign inst   = out_valid ? head[INST_W-1:0] : '0;
  assign out_pc = out_valid ? head[ADDR_W+INST_W-1:INST_W] : '0;

  assign out_opcode = inst[6:0];
  assign out_rd     = inst[11:7];
  assign out_funct3 = inst[14:12];
  assign out_rs1    = inst[19:15];
  assign out_rs2    = inst[24:20];
  assign out_funct7 = inst[31:25];

  always_comb begin
    out_imm = '0;
    case (imm_fmt(inst[6:0]))
      FMT_I:   out_imm = {{20{inst[31]}}, inst[31:20]};
      FMT_S:   out_imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      FMT_B:   out_imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      FMT_U:   out_imm = {inst[31:12], 12'b0};
      FMT_J:   out_imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: out_imm = '0;
    endcase
  end

endmodule
